// File: rtl/fetch_stage_pkg.sv
// Shared types for the fetch stage slice:
// fetch FSM encoding and the NOP word.
package cpu_pkg;

   typedef enum logic [1:0] {
      BOOT,
      FETCH,
      HOLD,
      DRAIN
   } fetch_state_t;

   localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory req/valid port.
// At most one request outstanding.
interface fetch_stage_if #(
   parameter int DATA_W = 32
);

   logic              imem_req;
   logic [DATA_W-1:0] imem_addr;
   logic [DATA_W-1:0] imem_rdata;
   logic              imem_valid;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rdata,
      input  imem_valid
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rdata,
      output imem_valid
   );

endinterface

// File: rtl/fetch_stage_pipe_reg.sv
// Generic pipeline register with load enable,
// flush and synchronous active-low reset.
module pipe_reg #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, variable-latency imem fetch,
// skid buffer for stalls, and the IF/ID register.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DATA_W   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              PCWrite,
   input  logic              IF_ID_Write,
   input  logic              branch_taken,
   input  logic [DATA_W-1:0] branch_target,
   input  logic              jump,
   input  logic [DATA_W-1:0] jump_target,
   fetch_stage_if.master     imem,
   output logic [DATA_W-1:0] IF_ID_instr,
   output logic [DATA_W-1:0] IF_ID_pcPlus4,
   output logic              IF_ID_valid
);

   localparam int IFID_W = 2 * DATA_W + 1;

   fetch_state_t      state;
   logic [DATA_W-1:0] pc;
   logic [DATA_W-1:0] skid;
   logic [DATA_W-1:0] old_addr;

   logic              advance;
   logic              redirect;
   logic [DATA_W-1:0] tgt_raw;
   logic [DATA_W-1:0] tgt;
   logic [DATA_W-1:0] pc_inc;

   logic              ifid_en;
   logic              ifid_clr;
   logic [IFID_W-1:0] ifid_d;
   logic [IFID_W-1:0] ifid_q;

   assign advance  = PCWrite & IF_ID_Write;
   assign redirect = branch_taken | jump;
   // the branch is the older instruction, so it wins
   assign tgt_raw  = branch_taken ? branch_target
                                  : jump_target;
   assign tgt      = {tgt_raw[DATA_W-1:2], 2'b00};
   assign pc_inc   = pc + DATA_W'(4);

   assign imem.imem_req  = (state == FETCH) ||
                           (state == DRAIN);
   assign imem.imem_addr = (state == DRAIN) ? old_addr
                                            : pc;

   always_comb begin
      ifid_en  = 1'b0;
      ifid_clr = 1'b0;
      ifid_d   = {imem.imem_rdata, pc_inc, 1'b1};
      unique case (state)
         BOOT: begin
            ifid_clr = redirect;
         end
         FETCH: begin
            if (redirect) begin
               ifid_clr = 1'b1;
            end else if (imem.imem_valid) begin
               ifid_en = advance;
            end else begin
               ifid_clr = advance;
            end
         end
         HOLD: begin
            ifid_d = {skid, pc_inc, 1'b1};
            if (redirect) begin
               ifid_clr = 1'b1;
            end else begin
               ifid_en = advance;
            end
         end
         DRAIN: begin
            ifid_clr = 1'b1;
         end
         default: begin
            ifid_clr = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= BOOT;
         pc       <= RESET_PC;
         skid     <= DATA_W'(INSTR_NOP);
         old_addr <= RESET_PC;
      end else begin
         unique case (state)
            BOOT: begin
               state <= FETCH;
               if (redirect) pc <= tgt;
            end
            FETCH: begin
               if (redirect) begin
                  pc <= tgt;
                  // request still in flight: retire it first
                  if (!imem.imem_valid) begin
                     state    <= DRAIN;
                     old_addr <= pc;
                  end
               end else if (imem.imem_valid) begin
                  if (advance) begin
                     pc <= pc_inc;
                  end else begin
                     skid  <= imem.imem_rdata;
                     state <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (redirect) begin
                  pc    <= tgt;
                  state <= FETCH;
               end else if (advance) begin
                  pc    <= pc_inc;
                  state <= FETCH;
               end
            end
            DRAIN: begin
               if (redirect) pc <= tgt;
               if (imem.imem_valid) state <= FETCH;
            end
            default: begin
               state <= BOOT;
            end
         endcase
      end
   end

   pipe_reg #(
      .WIDTH (IFID_W)
   ) u_if_id (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (ifid_en),
      .clr   (ifid_clr),
      .d     (ifid_d),
      .q     (ifid_q)
   );

   assign IF_ID_instr   = ifid_q[IFID_W-1 -: DATA_W];
   assign IF_ID_pcPlus4 = ifid_q[DATA_W -: DATA_W];
   assign IF_ID_valid   = ifid_q[0];

   a_valid_needs_req: assert property (
      @(posedge clk) disable iff (!rst_n)
      imem.imem_valid |-> imem.imem_req
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a
// latency-programmable instruction memory model.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        PCWrite;
   logic        IF_ID_Write;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [31:0] jump_target;
   logic [31:0] IF_ID_instr;
   logic [31:0] IF_ID_pcPlus4;
   logic        IF_ID_valid;

   int checks   = 0;
   int failures = 0;
   int lat      = 0;
   int cnt      = 0;

   fetch_stage_if #(.DATA_W(32)) imem ();

   fetch_stage #(
      .RESET_PC (32'h0000_0000),
      .DATA_W   (32)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .PCWrite       (PCWrite),
      .IF_ID_Write   (IF_ID_Write),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .imem          (imem),
      .IF_ID_instr   (IF_ID_instr),
      .IF_ID_pcPlus4 (IF_ID_pcPlus4),
      .IF_ID_valid   (IF_ID_valid)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(
      input logic [31:0] a
   );
      return a ^ 32'h5A00_0013;
   endfunction

   // responds once the request has waited lat cycles
   assign imem.imem_valid = imem.imem_req && (cnt >= lat);
   assign imem.imem_rdata = instr_of(imem.imem_addr);

   always @(posedge clk) begin
      if (!imem.imem_req || imem.imem_valid) cnt <= 0;
      else cnt <= cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(
      input string       tag,
      input logic [31:0] obs,
      input logic [31:0] exp
   );
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
      end
   endtask

   task automatic chk_ifid(
      input string       tag,
      input logic [31:0] ins,
      input logic [31:0] pc4,
      input logic        v
   );
      chk({tag, ".instr"}, IF_ID_instr, ins);
      chk({tag, ".pc4"}, IF_ID_pcPlus4, pc4);
      chk({tag, ".valid"}, {31'd0, IF_ID_valid},
          {31'd0, v});
   endtask

   task automatic chk_req(
      input string       tag,
      input logic        r,
      input logic [31:0] a
   );
      chk({tag, ".req"}, {31'd0, imem.imem_req},
          {31'd0, r});
      chk({tag, ".addr"}, imem.imem_addr, a);
   endtask

   task automatic chk_v(
      input string tag,
      input logic  v
   );
      chk({tag, ".valid"}, {31'd0, IF_ID_valid},
          {31'd0, v});
   endtask

   initial begin
      rst_n         = 1'b0;
      PCWrite       = 1'b1;
      IF_ID_Write   = 1'b1;
      branch_taken  = 1'b0;
      branch_target = 32'h0;
      jump          = 1'b0;
      jump_target   = 32'h0;
      lat           = 0;
      tick();
      tick();
      chk_req("rst", 1'b0, 32'h0);
      chk_ifid("rst", 32'h0, 32'h0, 1'b0);
      rst_n = 1'b1;

      // streaming with a 0-wait memory
      tick();
      chk_req("boot", 1'b1, 32'h0);
      chk_v("boot", 1'b0);
      tick();
      chk_ifid("s0", instr_of(32'h0), 32'h4, 1'b1);
      chk_req("s0", 1'b1, 32'h4);
      tick();
      chk_ifid("s1", instr_of(32'h4), 32'h8, 1'b1);
      tick();
      chk_ifid("s2", instr_of(32'h8), 32'hC, 1'b1);
      tick();
      chk_ifid("s3", instr_of(32'hC), 32'h10, 1'b1);
      chk_req("s3", 1'b1, 32'h10);

      // load-use stall while 0x10 returns
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      tick();
      chk_ifid("stall", instr_of(32'hC), 32'h10, 1'b1);
      chk_req("stall", 1'b0, 32'h10);
      PCWrite     = 1'b1;
      IF_ID_Write = 1'b1;
      tick();
      chk_ifid("skid", instr_of(32'h10), 32'h14, 1'b1);
      chk_req("skid", 1'b1, 32'h14);
      tick();
      chk_ifid("post", instr_of(32'h14), 32'h18, 1'b1);

      // 3-cycle memory latency
      lat = 2;
      tick();
      chk_req("lat1", 1'b1, 32'h18);
      chk_v("lat1", 1'b0);
      tick();
      chk_req("lat2", 1'b1, 32'h18);
      chk_v("lat2", 1'b0);
      tick();
      chk_ifid("lat3", instr_of(32'h18), 32'h1C, 1'b1);
      chk_req("lat3", 1'b1, 32'h1C);
      lat = 0;
      tick();
      chk_ifid("l0", instr_of(32'h1C), 32'h20, 1'b1);

      // branch while waiting on 0x20
      lat           = 2;
      branch_taken  = 1'b1;
      branch_target = 32'h40;
      tick();
      chk_req("drn1", 1'b1, 32'h20);
      chk_v("drn1", 1'b0);
      branch_taken = 1'b0;
      tick();
      chk_req("drn2", 1'b1, 32'h20);
      chk_v("drn2", 1'b0);
      tick();
      chk_req("bt1", 1'b1, 32'h40);
      chk_v("bt1", 1'b0);
      tick();
      chk_v("bt2", 1'b0);
      tick();
      chk_v("bt3", 1'b0);
      tick();
      chk_ifid("bt4", instr_of(32'h40), 32'h44, 1'b1);

      // branch and jump together: branch wins
      lat           = 0;
      branch_taken  = 1'b1;
      branch_target = 32'h80;
      jump          = 1'b1;
      jump_target   = 32'hC0;
      tick();
      chk_req("bj", 1'b1, 32'h80);
      chk_v("bj", 1'b0);
      branch_taken = 1'b0;
      jump         = 1'b0;
      tick();
      chk_ifid("bj2", instr_of(32'h80), 32'h84, 1'b1);

      // jump during HOLD drops the skid
      IF_ID_Write = 1'b0;
      tick();
      chk_req("hold", 1'b0, 32'h84);
      chk_ifid("hold", instr_of(32'h80), 32'h84, 1'b1);
      jump        = 1'b1;
      jump_target = 32'h100;
      tick();
      chk_req("hj", 1'b1, 32'h100);
      chk_v("hj", 1'b0);
      jump        = 1'b0;
      IF_ID_Write = 1'b1;
      tick();
      chk_ifid("hj2", instr_of(32'h100), 32'h104, 1'b1);

      // reset in DRAIN with a response arriving
      lat           = 3;
      branch_taken  = 1'b1;
      branch_target = 32'h200;
      tick();
      chk_req("rd", 1'b1, 32'h104);
      chk_v("rd", 1'b0);
      branch_taken = 1'b0;
      lat          = 1;
      rst_n        = 1'b0;
      tick();
      chk_req("rd_rst", 1'b0, 32'h0);
      chk_ifid("rd_rst", 32'h0, 32'h0, 1'b0);
      lat   = 0;
      rst_n = 1'b1;
      tick();
      chk_req("rb", 1'b1, 32'h0);
      chk_v("rb", 1'b0);
      tick();
      chk_ifid("rb2", instr_of(32'h0), 32'h4, 1'b1);

      // unaligned target, then pc+4 wraps to 0
      branch_taken  = 1'b1;
      branch_target = 32'hFFFF_FFFE;
      tick();
      chk_req("wr", 1'b1, 32'hFFFF_FFFC);
      chk_v("wr", 1'b0);
      branch_taken = 1'b0;
      tick();
      chk_ifid("wr2", instr_of(32'hFFFF_FFFC),
               32'h0, 1'b1);
      chk_req("wr2", 1'b1, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
